// File: rtl/arc4_seq.sv
// ARC4 phase sequencer. Runs the S-init, key-schedule and keystream engines in order over
// one rdy/en handshake each, and routes the single shared S-memory port to the owning engine.
`timescale 1ns/1ps
module arc4_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        init_en,
  input  logic        init_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_wrdata,
  input  logic        init_wren,
  output logic        ksa_en,
  input  logic        ksa_rdy,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_wrdata,
  input  logic        ksa_wren,
  output logic        prga_en,
  input  logic        prga_rdy,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_wrdata,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  output logic        err,
  output logic [15:0] cycles
);

  typedef enum logic [2:0] {
    StIdle,
    StInitGo,
    StInitWait,
    StKsaGo,
    StKsaWait,
    StPrgaGo,
    StPrgaWait
  } state_e;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic [15:0] cycles_q, cycles_d;
  logic        foreign_wren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      err_q    <= 1'b0;
      cycles_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
    end
  end

  // Each GO state forwards the engine's rdy as its en, so the pulse lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    init_en = 1'b0;
    ksa_en  = 1'b0;
    prga_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        rdy = 1'b1;
        if (en) state_d = StInitGo;
      end
      StInitGo: begin
        init_en = init_rdy;
        if (init_rdy) state_d = StInitWait;
      end
      StInitWait: begin
        if (init_rdy) state_d = StKsaGo;
      end
      StKsaGo: begin
        ksa_en = ksa_rdy;
        if (ksa_rdy) state_d = StKsaWait;
      end
      StKsaWait: begin
        if (ksa_rdy) state_d = StPrgaGo;
      end
      StPrgaGo: begin
        prga_en = prga_rdy;
        if (prga_rdy) state_d = StPrgaWait;
      end
      StPrgaWait: begin
        if (prga_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory ownership follows the registered phase; any other engine's write is dropped and flagged.
  always_comb begin
    s_addr       = 8'd0;
    s_wrdata     = 8'd0;
    s_wren       = 1'b0;
    foreign_wren = 1'b0;
    unique case (state_q)
      StInitGo, StInitWait: begin
        s_addr       = init_addr;
        s_wrdata     = init_wrdata;
        s_wren       = init_wren;
        foreign_wren = ksa_wren | prga_wren;
      end
      StKsaGo, StKsaWait: begin
        s_addr       = ksa_addr;
        s_wrdata     = ksa_wrdata;
        s_wren       = ksa_wren;
        foreign_wren = init_wren | prga_wren;
      end
      StPrgaGo, StPrgaWait: begin
        s_addr       = prga_addr;
        s_wrdata     = prga_wrdata;
        s_wren       = prga_wren;
        foreign_wren = init_wren | ksa_wren;
      end
      default: begin
        s_addr       = 8'd0;
        s_wrdata     = 8'd0;
        s_wren       = 1'b0;
        foreign_wren = 1'b0;
      end
    endcase
  end

  always_comb begin
    err_d    = err_q;
    cycles_d = cycles_q;
    if (state_q == StIdle) begin
      if (en) begin
        err_d    = 1'b0;
        cycles_d = 16'd0;
      end
    end else begin
      err_d = err_q | foreign_wren;
      if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
    end
  end

  assign err    = err_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: behavioural engine models, a pulse scoreboard keyed on cycle offset
// from the accepted en, and shared-port routing checks.
`timescale 1ns/1ps
module tb_arc4_seq;

  typedef struct packed {
    int kind;
    int off;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren, err;
  logic [15:0] cycles;

  logic [2:0]  m_rdy;
  logic [2:0]  eng_en;
  logic [2:0]  eff_rdy;
  int          cnt [3];
  int          busy [3];
  logic        ksa_hold = 1'b0;
  logic        init_force = 1'b0;

  int  cyc = 0;
  int  start = 0;
  int  mem_err = 0;
  ev_t obs_q [$];
  ev_t exp_q [$];
  int  rd_idx = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_e, got_e;
  int  off, m0;

  always #5 clk = ~clk;

  arc4_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rdy        (rdy),
    .init_en    (init_en),
    .init_rdy   (init_rdy),
    .init_addr  (init_addr),
    .init_wrdata(init_wrdata),
    .init_wren  (init_wren),
    .ksa_en     (ksa_en),
    .ksa_rdy    (ksa_rdy),
    .ksa_addr   (ksa_addr),
    .ksa_wrdata (ksa_wrdata),
    .ksa_wren   (ksa_wren),
    .prga_en    (prga_en),
    .prga_rdy   (prga_rdy),
    .prga_addr  (prga_addr),
    .prga_wrdata(prga_wrdata),
    .prga_wren  (prga_wren),
    .s_addr     (s_addr),
    .s_wrdata   (s_wrdata),
    .s_wren     (s_wren),
    .err        (err),
    .cycles     (cycles)
  );

  // Engine i with busy N keeps its owner in WAIT for N cycles: rdy low N-1 cycles after en.
  assign eng_en      = {prga_en, ksa_en, init_en};
  assign eff_rdy     = m_rdy & {1'b1, ~ksa_hold, 1'b1};
  assign init_rdy    = eff_rdy[0];
  assign ksa_rdy     = eff_rdy[1];
  assign prga_rdy    = eff_rdy[2];
  assign init_addr   = init_force ? 8'h55 : 8'h11;
  assign init_wrdata = 8'hA1;
  assign init_wren   = ~m_rdy[0] | init_force;
  assign ksa_addr    = 8'h22;
  assign ksa_wrdata  = 8'hB2;
  assign ksa_wren    = ~m_rdy[1];
  assign prga_addr   = 8'h33;
  assign prga_wrdata = 8'hC3;
  assign prga_wren   = ~m_rdy[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 3'b111;
      for (int i = 0; i < 3; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (eng_en[i] && eff_rdy[i]) begin
          if (busy[i] > 1) begin
            m_rdy[i] <= 1'b0;
            cnt[i]   <= busy[i] - 1;
          end
        end else if (!m_rdy[i]) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1) m_rdy[i] <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every en pulse with its offset, and check routing while an engine is busy.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) if (eng_en[i]) obs_q.push_back('{kind: i, off: cyc - start});
      if (!m_rdy[0] && (s_wren !== 1'b1 || s_addr !== 8'h11 || s_wrdata !== 8'hA1))
        mem_err <= mem_err + 1;
      if (!m_rdy[1] && (s_wren !== 1'b1 || s_addr !== 8'h22 || s_wrdata !== 8'hB2))
        mem_err <= mem_err + 1;
      if (!m_rdy[2] && (s_wren !== 1'b1 || s_addr !== 8'h33 || s_wrdata !== 8'hC3))
        mem_err <= mem_err + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_run(input int b0, input int b1, input int b2, input int stall);
    busy[0] = b0;
    busy[1] = b1;
    busy[2] = b2;
    exp_q.push_back('{kind: 0, off: 0});
    exp_q.push_back('{kind: 1, off: 1 + b0 + stall});
    exp_q.push_back('{kind: 2, off: 2 + b0 + b1 + stall});
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    start = cyc;
  endtask

  task automatic wait_done(input int limit, output int o);
    int k = 0;
    while (k < limit) begin
      @(negedge clk);
      if (rdy === 1'b1) break;
      k++;
    end
    o = cyc - start;
  endtask

  task test_reset;
    #2;
    n_checks++;
    if ({rdy, init_en, ksa_en, prga_en, s_wren, err} !== 6'b100000 || s_addr !== 8'd0 ||
        s_wrdata !== 8'd0 || cycles !== 16'd0)
      $display("FAIL reset_state: rdy=%b en=%b%b%b s_wren=%b err=%b addr=%h data=%h cycles=%0d, required rdy=1 rest 0",
               rdy, init_en, ksa_en, prga_en, s_wren, err, s_addr, s_wrdata, cycles);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdy !== 1'b1 || s_wren !== 1'b0 || cycles !== 16'd0)
      $display("FAIL reset_idle: rdy=%b s_wren=%b cycles=%0d, required 1 0 0", rdy, s_wren, cycles);
    else n_pass++;
  endtask

  task test_min_run;
    start_run(1, 1, 1, 0);
    wait_done(100, off);
    n_checks++;
    if (off !== 6 || cycles !== 16'd6 || err !== 1'b0)
      $display("FAIL min_run: latency=%0d cycles=%0d err=%b, required 6 6 0", off, cycles, err);
    else n_pass++;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL min_run_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
  endtask

  task test_normal;
    m0 = mem_err;
    start_run(256, 768, 40, 0);
    wait_done(5000, off);
    n_checks++;
    if (off !== 1067 || cycles !== 16'd1067 || err !== 1'b0)
      $display("FAIL normal_run: latency=%0d cycles=%0d err=%b, required 1067 1067 0",
               off, cycles, err);
    else n_pass++;
    n_checks++;
    if (mem_err !== m0) $display("FAIL normal_route: routing errors=%0d, required 0", mem_err - m0);
    else n_pass++;
    n_checks++;
    if (s_wren !== 1'b0 || s_addr !== 8'd0 || s_wrdata !== 8'd0)
      $display("FAIL idle_port: wren=%b addr=%h data=%h, required 0 00 00", s_wren, s_addr, s_wrdata);
    else n_pass++;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL normal_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
  endtask

  task test_ownership;
    m0 = mem_err;
    start_run(20, 30, 10, 0);
    repeat (27) @(posedge clk);
    #1;
    init_force = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_wren !== 1'b1 || s_addr !== 8'h22 || s_wrdata !== 8'hB2 || err !== 1'b0)
      $display("FAIL own_route: wren=%b addr=%h data=%h err=%b, required 1 22 b2 0",
               s_wren, s_addr, s_wrdata, err);
    else n_pass++;
    @(posedge clk);
    #1;
    init_force = 1'b0;
    n_checks++;
    if (err !== 1'b1) $display("FAIL own_err_set: err=%b, required 1", err);
    else n_pass++;
    wait_done(500, off);
    repeat (5) @(negedge clk);
    n_checks++;
    if (off !== 63 || err !== 1'b1 || mem_err !== m0)
      $display("FAIL own_err_hold: latency=%0d err=%b route_errs=%0d, required 63 1 0",
               off, err, mem_err - m0);
    else n_pass++;
    start_run(2, 2, 2, 0);
    n_checks++;
    if (err !== 1'b0) $display("FAIL own_err_clear: err=%b, required 0", err);
    else n_pass++;
    wait_done(100, off);
    n_checks++;
    if (off !== 9) $display("FAIL own_next_run: latency=%0d, required 9", off);
    else n_pass++;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL own_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
  endtask

  task test_go_stall;
    ksa_hold = 1'b1;
    start_run(4, 6, 3, 5);
    repeat (10) @(posedge clk);
    #1;
    ksa_hold = 1'b0;
    wait_done(200, off);
    n_checks++;
    if (off !== 21 || cycles !== 16'd21)
      $display("FAIL go_stall: latency=%0d cycles=%0d, required 21 21", off, cycles);
    else n_pass++;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL go_stall_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
  endtask

  task test_busy_ignore;
    int low = 0;
    start_run(256, 768, 40, 0);
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (289) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_done(5000, off);
    n_checks++;
    if (off !== 1067 || cycles !== 16'd1067)
      $display("FAIL busy_ignore: latency=%0d cycles=%0d, required 1067 1067", off, cycles);
    else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (rdy !== 1'b1) low++;
    end
    n_checks++;
    if (low !== 0) $display("FAIL busy_no_restart: rdy low for %0d idle cycles, required 0", low);
    else n_pass++;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL busy_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
    n_checks++;
    if (obs_q.size() !== rd_idx)
      $display("FAIL busy_extra_en: %0d extra pulses, required 0", obs_q.size() - rd_idx);
    else n_pass++;
  endtask

  task test_reset_mid_run;
    start_run(256, 768, 40, 0);
    repeat (278) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #0.005;
    n_checks++;
    if (s_wren !== 1'b0 || rdy !== 1'b1 || cycles !== 16'd0 || s_addr !== 8'd0 ||
        {init_en, ksa_en, prga_en} !== 3'b000)
      $display("FAIL mid_reset: s_wren=%b rdy=%b cycles=%0d addr=%h en=%b%b%b, required 0 1 0 00 000",
               s_wren, rdy, cycles, s_addr, init_en, ksa_en, prga_en);
    else n_pass++;
    #0.005;
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL mid_reset_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
    repeat (50) @(negedge clk);
    n_checks++;
    if (obs_q.size() !== rd_idx || rdy !== 1'b1)
      $display("FAIL mid_reset_abandon: extra pulses=%0d rdy=%b, required 0 1",
               obs_q.size() - rd_idx, rdy);
    else n_pass++;
    start_run(3, 4, 5, 0);
    wait_done(200, off);
    n_checks++;
    if (off !== 15 || cycles !== 16'd15 || err !== 1'b0)
      $display("FAIL mid_reset_rerun: latency=%0d cycles=%0d err=%b, required 15 15 0",
               off, cycles, err);
    else n_pass++;
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      if (rd_idx < obs_q.size()) got_e = obs_q[rd_idx]; else got_e = '{kind: -1, off: -1};
      rd_idx++;
      n_checks++;
      if (got_e !== exp_e)
        $display("FAIL rerun_sb: got en%0d@%0d, required en%0d@%0d",
                 got_e.kind, got_e.off, exp_e.kind, exp_e.off);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) busy[i] = 1;
    test_reset();
    test_min_run();
    test_normal();
    test_ownership();
    test_go_stall();
    test_busy_ignore();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arc4_seq.md
ARC4_SEQ -- requirements
Module: arc4_seq

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 The block SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: en  in  1  start request; rdy  out  1  idle and able to accept en.
REQ-004 The block SHALL have ports: init_en  out  1; init_rdy  in  1; init_addr  in  8; init_wrdata  in  8; init_wren  in  1  (S-init engine).
REQ-005 The block SHALL have ports: ksa_en  out  1; ksa_rdy  in  1; ksa_addr  in  8; ksa_wrdata  in  8; ksa_wren  in  1  (key-schedule engine).
REQ-006 The block SHALL have ports: prga_en  out  1; prga_rdy  in  1; prga_addr  in  8; prga_wrdata  in  8; prga_wren  in  1  (keystream/decrypt engine).
REQ-007 The block SHALL have ports: s_addr  out  8; s_wrdata  out  8; s_wren  out  1  (single shared S-memory port).
REQ-008 The block SHALL have ports: err  out  1  sticky: non-owning engine asserted wren; cycles  out  16  cycle count of last/current run.

Function
REQ-009 Handshake rule, all ports: en is sampled only when the matching rdy=1; the engine drops rdy on that same clock edge; rdy=1 again signals completion.
REQ-010 States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT.
REQ-011 IDLE: rdy=1; en=1 -> INIT_GO on next edge, cycles cleared to 0, err cleared; en=0 -> stay.
REQ-012 x_GO (x = init/ksa/prga): x_en = x_rdy (combinational from state); x_rdy=1 -> x_WAIT; x_rdy=0 -> stay in x_GO, x_en=0.
REQ-013 x_WAIT: x_en=0; x_rdy=1 -> next GO state (INIT->KSA->PRGA), PRGA_WAIT -> IDLE; x_rdy=0 -> stay.
REQ-014 Only one x_en SHALL be high in any cycle; every x_en SHALL be high for at most one cycle per phase.
REQ-015 rdy SHALL be 1 only in IDLE; en while rdy=0 SHALL be ignored (no queuing, no restart).
REQ-016 Memory mux from registered state: INIT_* -> init_*, KSA_* -> ksa_*, PRGA_* -> prga_*; IDLE -> s_addr=0, s_wrdata=0, s_wren=0.
REQ-017 Writes from non-owning engines SHALL never reach s_wren; such wren=1 in any non-IDLE cycle SHALL set err on the next edge, held until next accepted en.
REQ-018 cycles SHALL increment by 1 each cycle in any non-IDLE state, saturate at 16'hFFFF, and hold its value in IDLE.
REQ-019 Minimum run (each engine finishes 1 cycle after en) SHALL take 6 non-IDLE cycles; cycles then reads 6.
REQ-020 Latency from en accepted to rdy=1 SHALL equal 3 + sum of engine busy cycles + any GO-stall cycles.

Reset
REQ-021 rst_n=0 SHALL immediately force: state IDLE, rdy=1, all x_en=0, s_wren=0, s_addr=0, s_wrdata=0, err=0, cycles=0.
REQ-022 Reset mid-operation SHALL abandon the run with no further x_en pulses; operation resumes only on a new en after rst_n=1.
REQ-023 No output SHALL depend on uninitialised state after reset deassertion.

Verification
REQ-024 Normal run: reset, en pulse 1 cycle, engines busy 256/768/40 cycles -> init_en, ksa_en, prga_en each one pulse in order, rdy=1 after 1067 cycles, cycles=1067, err=0.
REQ-025 Ownership: during KSA_WAIT drive init_wren=1, init_addr=8'h55 for 1 cycle -> s_wren follows ksa_wren only, err=1 next edge, stays 1 until next en.
REQ-026 GO stall: hold ksa_rdy=0 for 5 cycles after init completes -> ksa_en stays 0 for those 5 cycles, then single pulse; cycles increases by 5.
REQ-027 Busy ignore: en pulses at cycles 10 and 300 of a run -> no extra x_en, run completes once, rdy=1 once.
REQ-028 Reset mid-run: rst_n=0 for 10 ps during KSA_WAIT -> s_wren=0 and rdy=1 within the same cycle, cycles=0, no prga_en; subsequent en runs full sequence normally.
